shift_normalizer_seq: RTL
=========================

# shift_normalizer_seq

Sequential normalizer that inverts a left/right barrel shift. It takes an 8-bit word and shifts it one bit per cycle toward the selected end until the end bit is 1, then reports the normalized word and the shift count. Shifting `data_out` the opposite way by `amt_out` in the existing `barrel_shifter_multi` reproduces the original `data_in`. The block sits beside the barrel shifter as its count-recovery / normalization engine, using a start/busy/done handshake.

## Interface
- `WIDTH`, 8: data width.
- `AMT_W`, 3: count width, equal to clog2(`WIDTH`).
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `data_in`  in  WIDTH  word to normalize; captured on the accepting edge.
- `ctrl`  in  1  direction; 1 = normalize left (toward MSB), 0 = normalize right (toward LSB); captured with `data_in`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `data_out`  out  WIDTH  normalized word.
- `amt_out`  out  AMT_W  number of bit positions shifted.
- `zero`  out  1  `data_in` was all zeros.

## Operation
- Two states: IDLE and SHIFT. Internal registers: `sreg[WIDTH]`, `cnt[AMT_W]`, `dir`.
- **IDLE:**
  - If `start`=1, load `sreg`=`data_in`, `dir`=`ctrl`, `cnt`=0.
  - Set `busy`=1 and go to SHIFT.
- **SHIFT, each edge:**
  - If `sreg`==0: set `zero`=1, `data_out`=0, `amt_out`=0, `done`=1, `busy`=0, go to IDLE.
  - Else if the aligned bit is 1 (`sreg[WIDTH-1]` when `dir`=1, `sreg[0]` when `dir`=0): set `data_out`=`sreg`, `amt_out`=`cnt`, `zero`=0, `done`=1, `busy`=0, go to IDLE.
  - Else shift `sreg` by one (left when `dir`=1, right when `dir`=0), zero-fill, and increment `cnt`.
- `cnt` never wraps, because a nonzero word aligns within WIDTH-1 shifts. The maximum `amt_out` is 7.
- Result invariants for a nonzero input:
  - `dir`=1: `data_out` == (`data_in` << `amt_out`) and `data_out[7]`=1.
  - `dir`=0: `data_out` == (`data_in` >> `amt_out`) and `data_out[0]`=1.
  - In both cases, shifting `data_out` the opposite way by `amt_out` reproduces `data_in` exactly.
- `data_out`, `amt_out` and `zero` are registered. They hold their last result until the next completion and do not change on `start`.
- `start` while `busy`=1 is ignored. `data_in` and `ctrl` changes during `busy` have no effect.
- `rst_n`=0 at any time, including mid-operation, forces IDLE immediately. The in-flight result is discarded and no `done` is generated.

## Timing
- Reset values: `busy`=0, `done`=0, `data_out`=0, `amt_out`=0, `zero`=0, state IDLE.
- Edge E0 accepts `start`. `busy` is high from after E0 until the completion edge.
- Nonzero input needing k shifts: completion is at edge E(k+1).
  - `done` is high for exactly the one cycle after E(k+1).
  - Latency range is 1 cycle (k=0) to 8 cycles (k=7).
- Zero input: completion at E1, latency 1.
- `done` and `busy` are never high together.
- Back-to-back: `start` held high during the `done` cycle is accepted at the next edge. Issue rate is one operation per latency + 1 cycles.

## Test plan
- Left normalize: `ctrl`=1, `data_in`=8'b0001_0110 -> `done` 4 cycles after E0, `amt_out`=3, `data_out`=8'b1011_0000, `zero`=0.
- Right normalize: `ctrl`=0, `data_in`=8'b0110_1000 -> `amt_out`=3, `data_out`=8'b0000_1101, `done` at E4.
- Extremes:
  - `ctrl`=1, 8'h80 -> `amt_out`=0, latency 1.
  - `ctrl`=1, 8'h01 -> `amt_out`=7, `data_out`=8'h80, latency 8.
  - `ctrl`=0, 8'h80 -> `amt_out`=7, `data_out`=8'h01.
- Zero input: 8'h00, either `ctrl` -> `zero`=1, `data_out`=0, `amt_out`=0, `done` at E1.
- Handshake:
  - `start` pulsed with 8'hFF during `busy` -> ignored; the first result is unchanged and exactly one `done` is produced.
  - `start` held through the `done` cycle -> second operation accepted at the next edge.
- Reset and round-trip:
  - `rst_n` low at E2 of a `ctrl`=1, 8'h01 run -> all outputs 0, no `done`; a new `start` after release completes normally.
  - 200 random (`data_in`, `ctrl`) pairs -> opposite-direction shift of `data_out` by `amt_out` equals `data_in`, and the aligned end bit is set.

Source files
------------

// File: rtl/shift_normalizer_seq.sv
// Sequential normalizer: shifts a word one bit per cycle toward the selected end
// until that end bit is set, reporting the normalized word and the shift count.
module shift_normalizer_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic [AMT_W-1:0] amt_out,
  output logic             zero
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] sreg_r, sreg_s;
  logic [AMT_W-1:0] cnt_r, cnt_s;
  logic             dir_r, dir_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [WIDTH-1:0] data_out_r, data_out_s;
  logic [AMT_W-1:0] amt_out_r, amt_out_s;
  logic             zero_r, zero_s;
  logic             aligned_s;

  // One-position zero-filling shift toward the MSB (left=1) or the LSB (left=0).
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v, input logic left);
    logic [WIDTH-1:0] r;
    if (left) begin
      r = {v[WIDTH-2:0], 1'b0};
    end else begin
      r = {1'b0, v[WIDTH-1:1]};
    end
    return r;
  endfunction

  // Aligned end bit for the captured direction.
  always_comb begin
    if (dir_r) begin
      aligned_s = sreg_r[WIDTH-1];
    end else begin
      aligned_s = sreg_r[0];
    end
  end

  // Next-state and next-output logic; results are held until the next completion.
  always_comb begin
    state_s    = state_r;
    sreg_s     = sreg_r;
    cnt_s      = cnt_r;
    dir_s      = dir_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    data_out_s = data_out_r;
    amt_out_s  = amt_out_r;
    zero_s     = zero_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          sreg_s  = data_in;
          dir_s   = ctrl;
          cnt_s   = {AMT_W{1'b0}};
          busy_s  = 1'b1;
          state_s = SHIFT;
        end else begin
          busy_s  = 1'b0;
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (sreg_r == {WIDTH{1'b0}}) begin
          zero_s     = 1'b1;
          data_out_s = {WIDTH{1'b0}};
          amt_out_s  = {AMT_W{1'b0}};
          done_s     = 1'b1;
          busy_s     = 1'b0;
          state_s    = IDLE;
        end else if (aligned_s) begin
          zero_s     = 1'b0;
          data_out_s = sreg_r;
          amt_out_s  = cnt_r;
          done_s     = 1'b1;
          busy_s     = 1'b0;
          state_s    = IDLE;
        end else begin
          // A nonzero word aligns within WIDTH-1 shifts, so cnt cannot wrap.
          sreg_s = shift_one(sreg_r, dir_r);
          cnt_s  = cnt_r + AMT_W'(1);
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      sreg_r     <= {WIDTH{1'b0}};
      cnt_r      <= {AMT_W{1'b0}};
      dir_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      data_out_r <= {WIDTH{1'b0}};
      amt_out_r  <= {AMT_W{1'b0}};
      zero_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      sreg_r     <= sreg_s;
      cnt_r      <= cnt_s;
      dir_r      <= dir_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      data_out_r <= data_out_s;
      amt_out_r  <= amt_out_s;
      zero_r     <= zero_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign data_out = data_out_r;
  assign amt_out  = amt_out_r;
  assign zero     = zero_r;

endmodule
